alu_share_arbiter: RTL and testbench
====================================

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; SHALL be 32 (fixed by the alu datapath).
REQ-002 Parameter CNT_W, default 16, width of the completed-operation counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req0_valid / req1_valid  input  1  requester n has an operation pending.
REQ-006 req0_ready / req1_ready  output  1  requester n's operation is accepted this cycle.
REQ-007 req0_data1, req0_data2 / req1_data1, req1_data2  input  DATA_W  operands.
REQ-008 req0_opcode / req1_opcode  input  4  ALU opcode.
REQ-009 rsp0_valid / rsp1_valid  output  1  result available for requester n.
REQ-010 rsp0_ready / rsp1_ready  input  1  requester n consumes its result.
REQ-011 rsp_data  output  DATA_W  registered result, shared by both response ports.
REQ-012 rsp_err  output  1  opcode of the held result was invalid.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 op_count  output  CNT_W  count of completed (consumed) responses.

Function
REQ-015 The block SHALL instantiate one alu and time-share it between requester 0 and requester 1.
REQ-016 ALU opcodes SHALL be: 0001 add, 0010 sub (Data1-Data2), 0011 and, 0100 or, 0101 xor; any other opcode gives result 0.
REQ-017 Add and sub SHALL wrap modulo 2^32; carry and borrow are discarded.
REQ-018 FSM states SHALL be IDLE, EXEC, RESP.
- IDLE: a grant occurs when either req_valid is high, then go to EXEC.
- EXEC: go to RESP unconditionally.
- RESP: go to IDLE when the owner's rsp_ready is high.
REQ-019 In IDLE, reqN_ready SHALL be asserted combinationally, for one cycle, only for the granted requester; it is 0 in EXEC and RESP.
REQ-020 On grant, the block SHALL latch the granted requester's data1, data2, opcode and its id (owner) into internal registers.
REQ-021 Arbitration SHALL be round-robin.
- A single valid requester is granted.
- When both are valid, the block grants the requester that is not last_grant.
- last_grant updates on every grant.
REQ-022 In EXEC, the ALU SHALL operate on the latched operands only.
- rsp_data is loaded with the ALU result at the end of EXEC.
- rsp_err is set to 1 if the opcode is outside 0001..0101, else 0.
REQ-023 In RESP, rspN_valid SHALL be high only for N = owner.
- rsp_data and rsp_err are held stable until the handshake completes.
- rsp_ready from the non-owner is ignored.
REQ-024 Latency: for an accept at cycle t, rspN_valid SHALL first be high at cycle t+2.
REQ-025 Minimum spacing between accepts SHALL be 3 cycles; no new grant occurs while in EXEC or RESP.
REQ-026 After a RESP handshake, the next grant SHALL be possible in the following cycle (IDLE).
REQ-027 op_count SHALL increment by 1 on each completed RESP handshake and wrap from 2^CNT_W-1 to 0.
REQ-028 Input changes on a requester after its accept SHALL NOT affect the in-flight operation.

Reset
REQ-029 While rst is high at a clock edge, the block SHALL set:
- state = IDLE
- last_grant = 1, so requester 0 wins the first tie
- rsp_data = 0, rsp_err = 0, op_count = 0, busy = 0
- all ready/valid outputs = 0 during the reset cycle
REQ-030 Reset during EXEC or RESP SHALL abandon the in-flight operation.
- No response is issued.
- op_count is not incremented.

Verification
REQ-031 Single op: req0 add, 00000005 + 0000000A, rsp0_ready=1 -> req0_ready at t, rsp0_valid at t+2, rsp_data=0000000F, rsp_err=0, op_count=1.
REQ-032 Tie after reset, both responders ready:
- Stimulus: req0 sub 5-A, req1 xor 5^A, both valid at t.
- Required: req0 granted at t with rsp_data=FFFFFFFB; req1 granted at t+3 with rsp_data=0000000F.
REQ-033 Fairness: both requesters held valid for 6 operations -> grants alternate 0,1,0,1,0,1; op_count=6.
REQ-034 Backpressure: rsp1_ready low for 4 cycles in RESP -> rsp1_valid, rsp_data and busy stay stable, req0_ready stays 0; handshake when rsp1_ready rises.
REQ-035 Invalid opcodes 0000 and 1111 -> rsp_data=00000000, rsp_err=1.
REQ-036 Reset and counter wrap:
- rst pulsed in EXEC -> next cycle rsp0_valid=0, busy=0, op_count=0.
- CNT_W=2 with 5 completed ops -> op_count=1.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Two requesters time-share one combinational ALU through an IDLE/EXEC/RESP handshake FSM.
// Round-robin tie-break; the result and error flag are registered and held until the owner consumes them.

module alu #(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    output logic [DATA_W-1:0] result,
    output logic              err
);

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (opcode)
            4'b0001: result = data1 + data2;
            4'b0010: result = data1 - data2;
            4'b0011: result = data1 & data2;
            4'b0100: result = data1 | data2;
            4'b0101: result = data1 ^ data2;
            default: err    = 1'b1;
        endcase
    end

endmodule

module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data1,
    input  logic [DATA_W-1:0] req0_data2,
    input  logic [3:0]        req0_opcode,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data1,
    input  logic [DATA_W-1:0] req1_data2,
    input  logic [3:0]        req1_opcode,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state, state_nxt;
    logic              last_grant;
    logic              owner;
    logic [DATA_W-1:0] data1_q, data2_q;
    logic [3:0]        opcode_q;
    logic              grant_vld, grant_id;
    logic              owner_rdy;
    logic              accept, handshake;
    logic [DATA_W-1:0] alu_result;
    logic              alu_err;

    alu #(.DATA_W(DATA_W)) u_alu (
        .opcode (opcode_q),
        .data1  (data1_q),
        .data2  (data2_q),
        .result (alu_result),
        .err    (alu_err)
    );

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        if (req0_valid && req1_valid)
            grant_id = ~last_grant;
        else
            grant_id = req1_valid;
        owner_rdy = owner ? rsp1_ready : rsp0_ready;
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        accept     = 1'b0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld && !rst) begin
                    accept     = 1'b1;
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_nxt  = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp0_valid = ~owner & ~rst;
                rsp1_valid = owner & ~rst;
                if (owner_rdy) begin
                    handshake = ~rst;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            data1_q    <= '0;
            data2_q    <= '0;
            opcode_q   <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner      <= grant_id;
                last_grant <= grant_id;
                data1_q    <= grant_id ? req1_data1  : req0_data1;
                data2_q    <= grant_id ? req1_data2  : req0_data2;
                opcode_q   <= grant_id ? req1_opcode : req0_opcode;
            end
            if (state == EXEC) begin
                rsp_data <= alu_result;
                rsp_err  <= alu_err;
            end
            if (handshake)
                op_count <= op_count + CNT_W'(1);
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: expected results are queued at accept time
// and popped when the owner's response appears.

module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_data1, req0_data2, req1_data1, req1_data2;
    logic [3:0]  req0_opcode, req1_opcode;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [15:0] op_count;

    // Second instance with a 2-bit counter for the wrap scenario.
    logic        w_rst, w_req0_valid, w_req0_ready, w_req1_ready;
    logic        w_rsp0_valid, w_rsp1_valid, w_rsp_err, w_busy;
    logic [31:0] w_rsp_data;
    logic [1:0]  w_op_count;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_data1(req0_data1), .req0_data2(req0_data2), .req0_opcode(req0_opcode),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_data1(req1_data1), .req1_data2(req1_data2), .req1_opcode(req1_opcode),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
    );

    alu_share_arbiter #(.DATA_W(32), .CNT_W(2)) dut_wrap (
        .clk(clk), .rst(w_rst),
        .req0_valid(w_req0_valid), .req0_ready(w_req0_ready),
        .req0_data1(32'd1), .req0_data2(32'd2), .req0_opcode(4'b0001),
        .req1_valid(1'b0), .req1_ready(w_req1_ready),
        .req1_data1(32'd0), .req1_data2(32'd0), .req1_opcode(4'b0000),
        .rsp0_valid(w_rsp0_valid), .rsp0_ready(1'b1),
        .rsp1_valid(w_rsp1_valid), .rsp1_ready(1'b1),
        .rsp_data(w_rsp_data), .rsp_err(w_rsp_err), .busy(w_busy), .op_count(w_op_count)
    );

    function automatic exp_t model(input logic id, input logic [3:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.id  = id;
        e.err = 1'b0;
        case (op)
            4'h1:    e.data = a + b;
            4'h2:    e.data = a - b;
            4'h3:    e.data = a & b;
            4'h4:    e.data = a | b;
            4'h5:    e.data = a ^ b;
            default: begin e.data = 32'h0; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic rand_req0;
        req0_opcode = 4'($urandom_range(1, 5));
        req0_data1  = $urandom;
        req0_data2  = $urandom;
    endtask

    task automatic rand_req1;
        req1_opcode = 4'($urandom_range(1, 5));
        req1_data1  = $urandom;
        req1_data2  = $urandom;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        tests_run++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_handshakes: got %b expected 0000",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || op_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b op_count=%0d expected busy=0 op_count=0", busy, op_count);
        end
        tests_run++;
        if (rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_rsp: rsp_data=%h rsp_err=%b expected 00000000/0", rsp_data, rsp_err);
        end
    endtask

    task automatic test_single_op;
        exp_t e;
        @(negedge clk);
        req0_valid = 1'b1; req0_opcode = 4'b0001;
        req0_data1 = 32'h5; req0_data2 = 32'hA;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_accept: req0_ready=%b expected 1", req0_ready);
        end
        sb.push_back(model(1'b0, req0_opcode, req0_data1, req0_data2));
        @(negedge clk);
        req0_valid = 1'b0; req0_data1 = 32'hDEAD_BEEF; req0_opcode = 4'b0011;
        #1;
        tests_run++;
        if (rsp0_valid !== 1'b0 || busy !== 1'b1 || req0_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_exec: rsp0_valid=%b busy=%b req0_ready=%b expected 0/1/0",
                     rsp0_valid, busy, req0_ready);
        end
        @(negedge clk);
        #1;
        tests_run++;
        e = sb.pop_front();
        if (rsp0_valid !== 1'b1 || rsp_data !== e.data || rsp_err !== e.err || rsp_data !== 32'h0000000F) begin
            tests_failed++;
            $display("FAIL single_rsp: valid=%b data=%h err=%b expected 1/%h/%b",
                     rsp0_valid, rsp_data, rsp_err, e.data, e.err);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (op_count !== 16'd1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_count: op_count=%0d busy=%b expected 1/0", op_count, busy);
        end
    endtask

    task automatic test_tie;
        exp_t e;
        do_reset();
        @(negedge clk);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_opcode = 4'b0010; req0_data1 = 32'h5; req0_data2 = 32'hA;
        req1_valid = 1'b1; req1_opcode = 4'b0101; req1_data1 = 32'h5; req1_data2 = 32'hA;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL tie_first: ready0=%b ready1=%b expected 1/0", req0_ready, req1_ready);
        end
        sb.push_back(model(1'b0, req0_opcode, req0_data1, req0_data2));
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        e = sb.pop_front();
        if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_data !== e.data || rsp_data !== 32'hFFFFFFFB) begin
            tests_failed++;
            $display("FAIL tie_rsp0: valid0=%b valid1=%b data=%h expected 1/0/%h",
                     rsp0_valid, rsp1_valid, rsp_data, e.data);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (req1_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL tie_second: req1_ready=%b expected 1", req1_ready);
        end
        sb.push_back(model(1'b1, req1_opcode, req1_data1, req1_data2));
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        e = sb.pop_front();
        if (rsp1_valid !== 1'b1 || rsp_data !== e.data || rsp_data !== 32'h0000000F) begin
            tests_failed++;
            $display("FAIL tie_rsp1: valid1=%b data=%h expected 1/%h", rsp1_valid, rsp_data, e.data);
        end
        @(negedge clk);
    endtask

    task automatic test_fairness;
        exp_t       e;
        logic [5:0] order = '0;
        int         grants = 0;
        int         rsps = 0;
        logic       chg0 = 1'b0, chg1 = 1'b0;
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        rand_req0();
        rand_req1();
        for (int cyc = 0; cyc < 200 && rsps < 6; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin req0_valid = 1'b1; req1_valid = 1'b1; end
            if (chg0) rand_req0();
            if (chg1) rand_req1();
            chg0 = 1'b0; chg1 = 1'b0;
            if (grants >= 6) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            #1;
            if (req0_ready) begin
                sb.push_back(model(1'b0, req0_opcode, req0_data1, req0_data2));
                if (grants < 6) order[grants] = 1'b0;
                grants++; chg0 = 1'b1;
            end
            if (req1_ready) begin
                sb.push_back(model(1'b1, req1_opcode, req1_data1, req1_data2));
                if (grants < 6) order[grants] = 1'b1;
                grants++; chg1 = 1'b1;
            end
            if (rsp0_valid || rsp1_valid) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL fair_rsp: response with empty scoreboard, data=%h", rsp_data);
                end else begin
                    e = sb.pop_front();
                    if (rsp1_valid !== e.id || rsp0_valid !== ~e.id || rsp_data !== e.data || rsp_err !== e.err) begin
                        tests_failed++;
                        $display("FAIL fair_rsp: id=%b data=%h err=%b expected id=%b data=%h err=%b",
                                 rsp1_valid, rsp_data, rsp_err, e.id, e.data, e.err);
                    end
                end
                rsps++;
            end
        end
        tests_run++;
        if (rsps != 6 || order !== 6'b101010) begin
            tests_failed++;
            $display("FAIL fair_order: rsps=%0d order(lsb first)=%b expected 6/101010", rsps, order);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (op_count !== 16'd6) begin
            tests_failed++;
            $display("FAIL fair_count: op_count=%0d expected 6", op_count);
        end
    endtask

    task automatic test_backpressure;
        exp_t e;
        @(negedge clk);
        rsp0_ready = 1'b1; rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_opcode = 4'b0011;
        req1_data1 = 32'hF0F0_1234; req1_data2 = 32'h0FF0_FF00;
        #1;
        tests_run++;
        if (req1_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_accept: req1_ready=%b expected 1", req1_ready);
        end
        sb.push_back(model(1'b1, req1_opcode, req1_data1, req1_data2));
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_opcode = 4'b0001; req0_data1 = 32'hFFFF_FFFF; req0_data2 = 32'h2;
        e = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_data !== e.data || rsp_err !== e.err ||
                busy !== 1'b1 || req0_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: v1=%b v0=%b data=%h err=%b busy=%b r0=%b expected 1/0/%h/%b/1/0",
                         i, rsp1_valid, rsp0_valid, rsp_data, rsp_err, busy, req0_ready, e.data, e.err);
            end
        end
        @(negedge clk);
        rsp1_ready = 1'b1;
        #1;
        tests_run++;
        if (rsp1_valid !== 1'b1 || rsp_data !== e.data) begin
            tests_failed++;
            $display("FAIL bp_release: v1=%b data=%h expected 1/%h", rsp1_valid, rsp_data, e.data);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (req0_ready !== 1'b1 || op_count !== 16'd7) begin
            tests_failed++;
            $display("FAIL bp_next: req0_ready=%b op_count=%0d expected 1/7", req0_ready, op_count);
        end
        sb.push_back(model(1'b0, req0_opcode, req0_data1, req0_data2));
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        e = sb.pop_front();
        if (rsp0_valid !== 1'b1 || rsp_data !== e.data || rsp_data !== 32'h1) begin
            tests_failed++;
            $display("FAIL bp_wrap_add: v0=%b data=%h expected 1/%h", rsp0_valid, rsp_data, e.data);
        end
        @(negedge clk);
    endtask

    task automatic test_invalid_opcode;
        exp_t       e;
        logic [3:0] ops [4] = '{4'b0000, 4'b1111, 4'b0100, 4'b0110};
        rsp0_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req0_valid = 1'b1; req0_opcode = ops[k];
            req0_data1 = $urandom; req0_data2 = $urandom;
            #1;
            tests_run++;
            if (req0_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL inv_accept[%0d]: req0_ready=%b expected 1", k, req0_ready);
            end
            sb.push_back(model(1'b0, req0_opcode, req0_data1, req0_data2));
            @(negedge clk);
            req0_valid = 1'b0;
            @(negedge clk);
            #1;
            tests_run++;
            e = sb.pop_front();
            if (rsp0_valid !== 1'b1 || rsp_data !== e.data || rsp_err !== e.err) begin
                tests_failed++;
                $display("FAIL inv_rsp[%0d]: v0=%b data=%h err=%b expected 1/%h/%b",
                         k, rsp0_valid, rsp_data, rsp_err, e.data, e.err);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        rsp0_ready = 1'b1;
        req0_valid = 1'b1; req0_opcode = 4'b0001; req0_data1 = 32'h10; req0_data2 = 32'h20;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rmid_accept: req0_ready=%b expected 1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (rsp0_valid !== 1'b0 || busy !== 1'b0 || op_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL rmid_state: v0=%b busy=%b op_count=%0d expected 0/0/0", rsp0_valid, busy, op_count);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (rsp0_valid !== 1'b0 || rsp_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL rmid_norsp: v0=%b data=%h expected 0/00000000", rsp0_valid, rsp_data);
        end
        sb.delete();
    endtask

    task automatic test_counter_wrap;
        int done = 0;
        @(negedge clk);
        w_rst = 1'b0; w_req0_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && done < 5; cyc++) begin
            @(negedge clk);
            #1;
            if (w_rsp0_valid) done++;
        end
        @(negedge clk);
        w_req0_valid = 1'b0;
        #1;
        tests_run++;
        if (done != 5 || w_op_count !== 2'd1) begin
            tests_failed++;
            $display("FAIL wrap_count: done=%0d op_count=%0d expected 5/1", done, w_op_count);
        end
    endtask

    initial begin
        rst = 1'b1; w_rst = 1'b1; w_req0_valid = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data1 = '0; req0_data2 = '0; req0_opcode = '0;
        req1_data1 = '0; req1_data2 = '0; req1_opcode = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        test_reset();
        test_single_op();
        test_tie();
        test_fairness();
        test_backpressure();
        test_invalid_opcode();
        test_reset_mid();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
